// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM encoding, nibble constants and decimal-range helper
// for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [NIBBLE_W-1:0] ADJ_ADD = 4'd3;
    function automatic int max_dec(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) r = r * 10;
        return r - 1;
    endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble pre-shift correction of one BCD digit
// (add 3 when the digit is 5 or more, 4-bit wrap, no carry-out).
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_digit,
    output logic [NIBBLE_W-1:0] o_digit
);
    assign o_digit = (i_digit >= ADJ_THRESH) ? i_digit + ADJ_ADD : i_digit;
endmodule

// File: rtl/seq_bin2bcd_converter.sv
// seq_bin2bcd_converter: iterative shift-add-3 binary-to-BCD converter, one shift per clock.
// Define BIN2BCD_FREE_RUN_EN to ignore start and convert bin continuously.
module seq_bin2bcd_converter
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIDTH-1:0]             bin,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [NIBBLE_W*DIGITS-1:0]   bcd
);
    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [31:0] MAX_DEC = 32'(max_dec(DIGITS));
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'd9}};

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_q;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_next;
    logic               w_go;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit(r_scratch[g*NIBBLE_W +: NIBBLE_W]),
            .o_digit(w_adj[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign w_next = {w_adj[BCD_W-2:0], r_shreg[WIDTH-1]};

`ifdef BIN2BCD_FREE_RUN_EN
    assign w_go = start | 1'b1;
`else
    assign w_go = start;
`endif

    // Outputs are written on the final shift so done and the new bcd appear in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bcd       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (w_go) begin
                        r_shreg   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_ovf_q   <= 32'(bin) > MAX_DEC;
                        busy      <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next;
                    r_shreg   <= r_shreg << 1;
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= DONE;
                        done     <= 1'b1;
                        overflow <= r_ovf_q;
                        bcd      <= r_ovf_q ? NINES : w_next;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
